// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Imported by the top and by the per-channel accumulator.
package clken_gen_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Width of the channel-select field; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clken_gen_ch.sv
// One phase-accumulator channel: produces a carry-driven enable pulse and holds
// a staged increment that is swapped in only on a period boundary.
module clken_gen_ch #(
  parameter int               ACC_W     = 32,
  parameter logic [ACC_W-1:0] INC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             clken,
  output logic             pending
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W-1:0] inc_next_reg;
  logic             pending_reg;
  logic             clken_reg;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  assign sum   = {1'b0, acc_reg} + {1'b0, inc_reg};
  assign carry = sum[ACC_W];

  // A running channel only retunes at a carry, so no period is ever cut short.
  assign apply = pending_reg && (!run || carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      clken_reg    <= 1'b0;
      inc_reg      <= INC_RESET;
      inc_next_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      if (run) begin
        acc_reg   <= sum[ACC_W-1:0];
        clken_reg <= carry;
      end else begin
        acc_reg   <= '0;
        clken_reg <= 1'b0;
      end

      if (apply) begin
        inc_reg     <= inc_next_reg;
        pending_reg <= 1'b0;
      end

      // The port only offers a write while nothing is pending, so this never
      // collides with an apply in the same cycle.
      if (cfg_we) begin
        inc_next_reg <= cfg_inc;
        pending_reg  <= 1'b1;
      end
    end
  end

  assign clken   = clken_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator gated on a synchronised PLL
// lock plus a settle interval, with a per-channel valid/ready rate port.
module clken_gen
  import clken_gen_pkg::*;
#(
  parameter int                      NUM_CH        = 3,
  parameter int                      ACC_W         = 32,
  parameter int                      SETTLE_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_RESET     = '0
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     pll_locked,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [ACC_W-1:0]         cfg_inc,
  output logic [NUM_CH-1:0]        clken,
  output logic                     locked
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CH_N  = 1 << CH_W;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lk;
  state_t                 state_reg;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   locked_reg;
  logic                   run_all;
  logic                   cfg_open;
  logic [NUM_CH-1:0]      pending;
  logic [CH_N-1:0]        pend_pad;
  logic                   xfer;

  // pll_locked is asynchronous to refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= WAIT;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      WAIT: begin
        if (lk) state_next = SETTLE;
      end
      SETTLE: begin
        if (!lk)                                  state_next = WAIT;
        else if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) state_next = RUN;
      end
      RUN: begin
        if (!lk) state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  // Channels stop in the very cycle lock is seen to drop, not one later.
  always_comb begin
    run_all  = (state_reg == RUN) && lk;
    cfg_open = (state_reg != WAIT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == SETTLE) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
    end
  end

  // Out-of-range channel numbers index the zero padding, so they read as ready.
  assign pend_pad  = CH_N'(pending);
  assign cfg_ready = cfg_open && !pend_pad[cfg_ch];
  assign xfer      = cfg_valid && cfg_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic ch_we;
      logic ch_run;

      assign ch_we  = xfer && (cfg_ch == CH_W'(gi));
      assign ch_run = run_all && ch_en[gi];

      clken_gen_ch #(
        .ACC_W     (ACC_W),
        .INC_RESET (INC_RESET[gi*ACC_W +: ACC_W])
      ) u_ch (
        .clk     (refclk),
        .rst_n   (rst_n),
        .run     (ch_run),
        .cfg_we  (ch_we),
        .cfg_inc (cfg_inc),
        .clken   (clken[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign locked = locked_reg;

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen with ACC_W=4, SETTLE_CYCLES=4, NUM_CH=3.
// Expected patterns are hand-computed from the accumulator arithmetic.
module tb_clken_gen;

  localparam int NUM_CH        = 3;
  localparam int ACC_W         = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam logic [NUM_CH*ACC_W-1:0] INC_RESET = {4'd0, 4'd0, 4'd6};

  logic              refclk     = 1'b0;
  logic              rst_n      = 1'b0;
  logic              pll_locked = 1'b0;
  logic [NUM_CH-1:0] ch_en      = '0;
  logic              cfg_valid  = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch     = '0;
  logic [ACC_W-1:0]  cfg_inc    = '0;
  logic [NUM_CH-1:0] clken;
  logic              locked;

  int n_checks = 0;
  int n_pass   = 0;

  clken_gen #(
    .NUM_CH        (NUM_CH),
    .ACC_W         (ACC_W),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .INC_RESET     (INC_RESET)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .ch_en      (ch_en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_inc    (cfg_inc),
    .clken      (clken),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-16s = %0h", tag, obs);
    end else begin
      $display("FAIL %-16s got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Shift one channel's clken into a pattern word, oldest bit highest.
  task automatic run_pattern(input int n, input int ch, output logic [31:0] pat);
    pat = '0;
    for (int i = 0; i < n; i++) begin
      step();
      pat = {pat[30:0], clken[ch]};
    end
  endtask

  task automatic count_pulses(input int n, input int ch, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (clken[ch]) cnt++;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [ACC_W-1:0] inc);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    step();
    cfg_valid = 1'b0;
    $display("cfg  ch=%0d inc=%0d", ch, inc);
  endtask

  // Release from reset with lock already high and walk the 7-cycle lock-up.
  task automatic lock_up(input string pfx);
    logic [NUM_CH-1:0] seen;
    seen = '0;
    for (int i = 1; i <= 7; i++) begin
      step();
      seen = seen | clken;
      if (i == 2) check({pfx, "_wait_rdy"}, cfg_ready, 1'b0);
      if (i == 3) check({pfx, "_settle_rdy"}, cfg_ready, 1'b1);
      if (i == 6) check({pfx, "_lock_early"}, locked, 1'b0);
    end
    check({pfx, "_lock_rise"}, locked, 1'b1);
    check({pfx, "_quiet"}, seen, '0);
  endtask

  initial begin
    logic [31:0] pat;
    int          cnt;

    // Reset and lock sequencing.
    ch_en = 3'b001;
    repeat (3) step();
    check("rst_clken", clken, 3'b000);
    check("rst_locked", locked, 1'b0);
    check("rst_ready", cfg_ready, 1'b0);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    lock_up("s1");

    // Fractional rate: inc=6 -> 6,12,2c,8,14,4c,10,0c.
    run_pattern(8, 0, pat);
    check("frac_p1", pat, 32'b00100101);
    run_pattern(8, 0, pat);
    check("frac_p2", pat, 32'b00100101);

    // Glitch-free retune to inc=8 starting from phase 0.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_inc   = 4'd8;
    #1;
    check("retune_rdy0", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("retune_busy1", cfg_ready, 1'b0);
    step();
    check("retune_busy2", cfg_ready, 1'b0);
    check("old_rate_a18", clken[0], 1'b0);
    step();
    check("carry_apply", clken[0], 1'b1);
    check("retune_ready", cfg_ready, 1'b1);
    run_pattern(6, 0, pat);
    check("new_rate", pat, 32'b010101);

    // Lock loss in RUN, then re-lock with inc=6 written during SETTLE.
    pll_locked = 1'b0;
    step();
    step();
    check("ll_locked_hold", locked, 1'b1);
    check("ll_last_pulse", clken[0], 1'b1);
    step();
    check("ll_locked", locked, 1'b0);
    check("ll_clken", clken, 3'b000);
    check("ll_ready", cfg_ready, 1'b0);
    pll_locked = 1'b1;
    repeat (3) step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_inc   = 4'd6;
    #1;
    check("settle_cfg_rdy", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    check("settle_busy", cfg_ready, 1'b0);
    step();
    check("settle_apply", cfg_ready, 1'b1);
    step();
    check("relock_early", locked, 1'b0);
    step();
    check("relock_rise", locked, 1'b1);
    run_pattern(8, 0, pat);
    check("relock_frac", pat, 32'b00100101);

    // Disable on a carry cycle, then restart from phase 0.
    ch_en = 3'b000;
    cfg_write(2'd1, 4'd3);
    step();
    ch_en = 3'b010;
    run_pattern(5, 1, pat);
    check("dis_pre", pat, 32'b00000);
    ch_en = 3'b000;
    step();
    check("dis_on_carry", clken[1], 1'b0);
    ch_en = 3'b010;
    run_pattern(6, 1, pat);
    check("reen_phase0", pat, 32'b000001);

    // inc=0 never pulses; inc=15 pulses 15 of 16.
    ch_en = 3'b100;
    count_pulses(16, 2, cnt);
    check("inc0_pulses", cnt, 0);
    ch_en = 3'b000;
    cfg_write(2'd2, 4'd15);
    step();
    ch_en = 3'b100;
    count_pulses(16, 2, cnt);
    check("inc15_pulses", cnt, 15);

    // Out-of-range channel: accepted, nothing changes.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_inc   = 4'd5;
    #1;
    check("oor_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_ch = 2'(c);
      #1;
      check($sformatf("oor_rdy_ch%0d", c), cfg_ready, 1'b1);
    end
    count_pulses(16, 2, cnt);
    check("oor_nochange", cnt, 15);

    // Async reset mid-RUN with ch0 update pending.
    ch_en = 3'b101;
    step();
    step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_inc   = 4'd8;
    step();
    cfg_valid = 1'b0;
    check("pre_rst_pulse", clken[0], 1'b1);
    check("pre_rst_busy", cfg_ready, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_clken", clken, 3'b000);
    check("arst_locked", locked, 1'b0);
    check("arst_ready", cfg_ready, 1'b0);
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    lock_up("s6");
    run_pattern(8, 0, pat);
    check("rst_inc_ch0", pat, 32'b00100101);
    count_pulses(8, 2, cnt);
    check("rst_inc_ch2", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised successor to the fixed three-output PLL wrapper.
- Runs from one fabric clock, normally the 80 MHz PLL output, and generates NUM_CH independent fractional-rate clock-enable pulse trains using phase accumulators.
- Each channel's rate is reprogrammable at run time through a valid/ready config port, and every rate change is glitch-free.
- Gates all enables on a synchronised PLL lock plus a settle interval, and reports its own `locked` status to the core (video, audio and CPU clock enables).

Parameters:
- NUM_CH, 3: number of enable channels (1..8).
- ACC_W, 32: accumulator width. Channel rate is f_clk * inc / 2^ACC_W.
- SETTLE_CYCLES, 1024: cycles to wait after synchronised PLL lock before RUN (must be at least 1).
- INC_RESET, {NUM_CH{ACC_W'h0}}: per-channel increment loaded at reset (flattened NUM_CH*ACC_W vector).

Ports:
- refclk  in  1  fabric clock; all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock flag, asynchronous to refclk; synchronised internally with 2 flops.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_ch  in  $clog2(NUM_CH) (minimum 1)  target channel.
- cfg_inc  in  ACC_W  new increment.
- clken  out  NUM_CH  one-cycle enable pulses, registered.
- locked  out  1  high only in RUN.

Behaviour:
- Reset values:
  - clken=0, locked=0, cfg_ready=0.
  - State=WAIT, accumulators=0, increments=INC_RESET, pending flags=0, settle counter=0.
- FSM, on synchronised lock `lk`:
  - WAIT: if lk, go to SETTLE and clear the counter.
  - SETTLE: count up; if !lk, go to WAIT; at count SETTLE_CYCLES-1, go to RUN.
  - RUN: if !lk, go to WAIT. In the same cycle clken<=0, locked<=0, accumulators cleared.
- locked is registered and equals (state==RUN).
- Accumulator in RUN with ch_en[i]=1:
  - sum = {1'b0, acc} + inc, computed in ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0]; clken[i] <= sum[ACC_W].
  - The first accumulate happens in the first RUN cycle, so the earliest pulse is 1 cycle after RUN entry.
- Outside RUN, or with ch_en[i]=0: acc[i] <= 0 and clken[i] <= 0.
- Re-enabling a channel restarts it from phase 0.
- inc=0 gives no pulses. The carry can never occur on two consecutive accumulates unless inc >= 2^(ACC_W-1).
- Config handshake:
  - cfg_ready = (state != WAIT) && !pending[cfg_ch]. It is combinational on cfg_ch.
  - A transfer happens on cfg_valid && cfg_ready: latch inc_next[cfg_ch], set pending[cfg_ch].
  - cfg_ch >= NUM_CH is ready and the write is silently dropped.
- Applying a pending increment:
  - A channel that is running applies it in the cycle its carry occurs. The new increment is used from the next accumulate, so no partial-period glitch.
  - A channel that is not running (disabled, or SETTLE) applies it on the next cycle.
  - pending clears in the apply cycle, so cfg_ready for that channel returns the following cycle.
- Simultaneous events:
  - Lock loss in the same cycle as a config transfer: the transfer is kept and applies on the next cycle, since the channel is no longer running.
  - ch_en falling on a carry cycle: that carry's pulse is suppressed (disable wins).
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Decomposition:
- Package clken_gen_pkg:
  - state enum {WAIT, SETTLE, RUN};
  - localparam SYNC_STAGES=2;
  - width helper function for cfg_ch.
- Sub-module clken_gen_ch, instantiated NUM_CH times. It holds one accumulator, inc, inc_next and pending, with inputs run, cfg_we, cfg_inc, and outputs clken, pending.
- The top holds the synchroniser, FSM, settle counter and cfg decode.

Test Plan (ACC_W=4, SETTLE_CYCLES=4, NUM_CH=3 unless noted):
- Lock sequencing: rst_n released, pll_locked high at t0 -> locked rises 2 (sync) + 1 (WAIT) + 4 (SETTLE) cycles later. clken stays 0 throughout.
- Fractional rate: ch0 inc=6, ch_en=001, in RUN -> clken[0] pattern over 8 cycles has pulses on accumulate 3, 6 and 8 (acc 6, 12, 2c, 8, 14, 4c, 10, 0c). Exactly 3 pulses per 8 cycles, repeating.
- Glitch-free retune: ch0 running inc=6, write inc=8 mid-period -> cfg_ready for ch0 drops. Old rate continues until the next carry, then pulses every 2 cycles. cfg_ready returns 1 cycle after the apply.
- Lock loss: pll_locked falls in RUN -> locked and clken are 0 within 3 cycles. On re-lock, the full settle runs again and ch0 restarts from phase 0 with the same pattern as scenario 2.
- Disable/edge cases:
  - ch_en[1] dropped on a carry cycle -> no pulse.
  - inc=0 -> never pulses.
  - inc=15 -> pulses 15 of every 16 cycles.
  - cfg_ch=3 (NUM_CH=3) -> accepted, with no state change.
- Async reset mid-RUN with a pending update: all outputs 0 immediately, pending cleared, INC_RESET restored (checked via the rate after re-lock).
